// File: rtl/led_fade_drv_if.sv
// LED fade driver bus: LEDCON target byte in, PWM LED pins and status out.
// The master side (register wrapper) drives LEDCON; the slave side is led_fade_drv.
interface led_fade_drv_if;
  logic [7:0] LEDCON;
  logic [7:0] LED;
  logic       BUSY;
  logic [2:0] TPS;

  modport master (
    output LEDCON,
    input  LED,
    input  BUSY,
    input  TPS
  );

  modport slave (
    input  LEDCON,
    output LED,
    output BUSY,
    output TPS
  );
endinterface

// File: rtl/led_fade_drv.sv
// LED fade driver: turns each LEDCON bit into a brightness target and drives the LED
// pins with 8-bit PWM, ramping brightness by STEP once every PRESCALE cycles.
// Build option: define LED_FADE_DRV_FADE_EN to enable fading. Without it, LED is
// LEDCON registered once, and BUSY/TPS are tied low.
module led_fade_drv #(
  parameter int unsigned PRESCALE = 1000,  // PCLK cycles per fade tick, >= 1
  parameter int unsigned STEP     = 1      // brightness change per tick, 1..255
) (
  input logic           PCLK,
  input logic           PRESERN,
  led_fade_drv_if.slave bus
);

`ifdef LED_FADE_DRV_FADE_EN

  localparam int unsigned     PsW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PsW-1:0]  PsMax = PsW'(PRESCALE - 1);
  localparam logic [8:0]      Step9 = 9'(STEP);

  logic [7:0]     ledcon_q;
  logic [PsW-1:0] psc_q, psc_d;
  logic           tick;
  logic [7:0]     pwm_cnt_q, pwm_cnt_d;
  logic [7:0]     bright_q [8];
  logic [7:0]     bright_d [8];
  logic [7:0]     led_q, led_d;
  logic           busy;
  logic           pwm_wrap;

  // Prescaler: tick fires in the last cycle of each PRESCALE-cycle period.
  always_comb begin
    tick  = (psc_q == PsMax);
    psc_d = tick ? '0 : psc_q + PsW'(1);
  end

  // Free-running PWM counter, wraps naturally at 8 bits.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 8'd1;
    pwm_wrap  = (pwm_cnt_q == 8'hFF);
  end

  // Brightness ramp with 9-bit saturating arithmetic, direction from registered target.
  always_comb begin
    logic [8:0] up9;
    logic [8:0] dn9;
    up9 = '0;
    dn9 = '0;
    for (int i = 0; i < 8; i++) begin
      bright_d[i] = bright_q[i];
      up9 = {1'b0, bright_q[i]} + Step9;
      dn9 = {1'b0, bright_q[i]} - Step9;
      if (tick) begin
        if (ledcon_q[i]) begin
          bright_d[i] = up9[8] ? 8'hFF : up9[7:0];
        end else begin
          // Borrow out of bit 8 means the result went below zero.
          bright_d[i] = dn9[8] ? 8'h00 : dn9[7:0];
        end
      end
    end
  end

  // PWM compare; full brightness is forced on so 255 never shows a dark slot.
  always_comb begin
    led_d = '0;
    for (int i = 0; i < 8; i++) begin
      led_d[i] = (bright_q[i] == 8'hFF) || (pwm_cnt_q < bright_q[i]);
    end
  end

  // BUSY: any LED not yet at its fully-on or fully-off target.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bright_q[i] != (ledcon_q[i] ? 8'hFF : 8'h00)) begin
        busy = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      ledcon_q  <= '0;
      psc_q     <= '0;
      pwm_cnt_q <= '0;
      led_q     <= '0;
      for (int i = 0; i < 8; i++) begin
        bright_q[i] <= '0;
      end
    end else begin
      ledcon_q  <= bus.LEDCON;
      psc_q     <= psc_d;
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
      for (int i = 0; i < 8; i++) begin
        bright_q[i] <= bright_d[i];
      end
    end
  end

  assign bus.LED  = led_q;
  assign bus.BUSY = busy;
  assign bus.TPS  = {busy, pwm_wrap, tick};

`else

  logic [7:0] led_q;

  // Plain one-cycle pass-through of the target byte.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      led_q <= '0;
    end else begin
      led_q <= bus.LEDCON;
    end
  end

  assign bus.LED  = led_q;
  assign bus.BUSY = 1'b0;
  assign bus.TPS  = 3'b000;

`endif

endmodule
